// File: rtl/toi2s_pkg.sv
// Shared definitions for the toI2S PWM blocks: mode encoding, the
// register-bank view of the PWM controls, and the period-boundary rule
// that both the timebase and any future PWM variants agree on.
package toi2s_pkg;

  // Counter alignment mode, one bit wide so it maps directly onto a register field.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Upper bounds of the supported configuration range.
  localparam int PWM_MAX_CHANNELS = 8;
  localparam int PWM_MAX_WIDTH    = 12;
  localparam int PWM_PRESCALE_W   = 4;

  // Register-bank fields feeding the PWM block, sized for the largest build.
  typedef struct packed {
    logic [PWM_MAX_CHANNELS-1:0][PWM_MAX_WIDTH-1:0] duty;
    pwm_mode_e                                      mode;
    logic [PWM_PRESCALE_W-1:0]                      prescale;
    logic [PWM_MAX_CHANNELS-1:0]                    polarity;
  } pwm_regs_t;

  // True when the current count is the last one of a period.
  // Edge mode ends on the top count; center mode ends on count 1 while
  // falling, so the following count is 0 and the next period starts there.
  function automatic logic pwm_at_boundary(
    input pwm_mode_e mode_sel,
    input logic      count_down,
    input logic      at_max,
    input logic      at_one
  );
    if (mode_sel == PWM_EDGE) begin
      return at_max;
    end
    return count_down && at_one;
  endfunction

endpackage

// File: rtl/pwm_mc_timebase.sv
// Shared PWM timebase: prescaler, up or up/down period counter and
// period-boundary detection. All channels compare against this one counter.
module pwm_mc_timebase
  import toi2s_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  pwm_mode_e             mode_act,
  input  logic [PRESCALE_W-1:0] prescale_act,
  output logic [WIDTH-1:0]      cnt,
  output logic                  boundary
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
  logic [WIDTH-1:0]      cnt_reg, cnt_next;
  logic                  dir_reg, dir_next;   // 1 = counting down (center mode)
  logic                  tick;

  // The counter only moves on a prescaler tick; a disabled timebase never ticks.
  assign tick     = enable && (pcnt_reg == prescale_act);
  assign boundary = tick && pwm_at_boundary(mode_act, dir_reg,
                                            cnt_reg == CNT_MAX,
                                            cnt_reg == CNT_ONE);
  assign cnt      = cnt_reg;

  // Next-state logic for prescaler, counter and direction.
  // Every period, in either mode, begins at count 0 counting up, so a
  // boundary simply reloads that state. This also gives the restart-at-0
  // behaviour when the mode changes at a boundary.
  always_comb begin
    pcnt_next = pcnt_reg;
    cnt_next  = cnt_reg;
    dir_next  = dir_reg;
    if (!enable) begin
      pcnt_next = '0;
      cnt_next  = '0;
      dir_next  = 1'b0;
    end else begin
      pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
      if (boundary) begin
        cnt_next = '0;
        dir_next = 1'b0;
      end else if (tick) begin
        if (mode_act == PWM_EDGE) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (!dir_reg) begin
          if (cnt_reg == CNT_MAX) begin
            dir_next = 1'b1;
            cnt_next = cnt_reg - 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
    end
  end

  // Timebase state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_reg <= '0;
      cnt_reg  <= '0;
      dir_reg  <= 1'b0;
    end else begin
      pcnt_reg <= pcnt_next;
      cnt_reg  <= cnt_next;
      dir_reg  <= dir_next;
    end
  end

endmodule

// File: rtl/pwm_mc.sv
// Multi-channel PWM generator. One shared timebase, shadowed duty, mode
// and prescale settings that only change at period boundaries, and one
// registered comparator per channel with optional output inversion.
module pwm_mc
  import toi2s_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      duty_load,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      load_ack
);

  // Active settings, updated only at period boundaries.
  pwm_mode_e                 mode_act_reg;
  logic [PRESCALE_W-1:0]     prescale_act_reg;
  logic [CHANNELS*WIDTH-1:0] duty_act_reg;

  // Pending duty capture waiting for the next boundary.
  logic [CHANNELS*WIDTH-1:0] duty_pend_reg;
  logic                      pend_flag_reg;

  // Event pipeline: the boundary fires on the last count of a period,
  // the first count of the new period is in the counter one cycle later,
  // and its compare result reaches the pins one cycle after that. The
  // period/ack pulses are delayed to line up with that first output.
  logic                      boundary_d_reg;
  logic                      ack_d_reg;
  logic                      enable_d_reg;

  logic [CHANNELS-1:0]       pwm_out_reg;
  logic                      period_start_reg;
  logic                      load_ack_reg;

  logic [WIDTH-1:0]          cnt;
  logic                      boundary;
  logic [CHANNELS-1:0]       raw;

  pwm_mc_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode_act     (mode_act_reg),
    .prescale_act (prescale_act_reg),
    .cnt          (cnt),
    .boundary     (boundary)
  );

  // Per-channel comparators against the shared counter.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign raw[gi] = cnt < duty_act_reg[gi*WIDTH +: WIDTH];
  end

  // Shadow registers: capture on duty_load, transfer at the boundary.
  // A capture in the boundary cycle becomes the new pending value while the
  // previously pending one (if any) is what gets transferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_act_reg     <= PWM_EDGE;
      prescale_act_reg <= '0;
      duty_act_reg     <= '0;
      duty_pend_reg    <= '0;
      pend_flag_reg    <= 1'b0;
      ack_d_reg        <= 1'b0;
      boundary_d_reg   <= 1'b0;
      enable_d_reg     <= 1'b0;
    end else begin
      if (boundary) begin
        mode_act_reg     <= pwm_mode_e'(mode);
        prescale_act_reg <= prescale;
      end
      if (boundary && pend_flag_reg) begin
        duty_act_reg <= duty_pend_reg;
      end
      if (duty_load) begin
        duty_pend_reg <= duty;
        pend_flag_reg <= 1'b1;
      end else if (boundary) begin
        pend_flag_reg <= 1'b0;
      end
      ack_d_reg      <= boundary && pend_flag_reg;
      boundary_d_reg <= boundary;
      enable_d_reg   <= enable;
    end
  end

  // Output registers: compare result with polarity, period and ack pulses.
  // While disabled the pins sit at their inactive level (the polarity value).
  // The first enabled cycle is treated as the start of a fresh period.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out_reg      <= '0;
      period_start_reg <= 1'b0;
      load_ack_reg     <= 1'b0;
    end else if (!enable) begin
      pwm_out_reg      <= polarity;
      period_start_reg <= 1'b0;
      load_ack_reg     <= 1'b0;
    end else begin
      pwm_out_reg      <= raw ^ polarity;
      period_start_reg <= boundary_d_reg || !enable_d_reg;
      load_ack_reg     <= ack_d_reg;
    end
  end

  assign pwm_out      = pwm_out_reg;
  assign period_start = period_start_reg;
  assign load_ack     = load_ack_reg;

endmodule

// File: tb/tb_pwm_mc.sv
// Directed bench for pwm_mc (4 channels, 8-bit, 4-bit prescale).
// Observations are taken 1 ns after each rising edge; "index i" below is
// the i-th sample of a period, where index 0 carries period_start.
module tb_pwm_mc;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mode;
  logic [PW-1:0] prescale;
  logic [CH*W-1:0] duty;
  logic          duty_load;
  logic [CH-1:0] polarity;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic          load_ack;

  int total = 0;
  int bad   = 0;

  // Results of the last measurement window.
  int m_hi [CH];
  int m_first_low [CH];
  int m_ps;
  int m_ack;

  always #5 clk = ~clk;

  pwm_mc #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .prescale     (prescale),
    .duty         (duty),
    .duty_load    (duty_load),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .load_ack     (load_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    duty = {d3, d2, d1, d0};
  endtask

  task automatic pulse_load();
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
  endtask

  // Sample n consecutive cycles starting with the current one; ends one
  // step past the last sample.
  task automatic measure(input int n);
    for (int c = 0; c < CH; c++) begin
      m_hi[c] = 0;
      m_first_low[c] = -1;
    end
    m_ps = 0;
    m_ack = 0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (pwm_out[c]) m_hi[c]++;
        else if (m_first_low[c] < 0) m_first_low[c] = i;
      end
      if (period_start) m_ps++;
      if (load_ack) m_ack++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; mode = 1'b0; prescale = '0;
    duty = '0; duty_load = 1'b0; polarity = '1;
    repeat (3) step();
    total++; if (pwm_out !== 4'b0000) begin bad++; $display("FAIL reset_pwm got=%b exp=0000", pwm_out); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b exp=0", period_start); end
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
    $display("test_reset done");
  endtask

  task automatic test_enable_polarity();
    int n;
    enable = 1'b0; polarity = 4'b0001; reset = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (pwm_out !== 4'b0001) begin bad++; $display("FAIL dis_pwm got=%b exp=0001", pwm_out); end
      total++; if (period_start !== 1'b0) begin bad++; $display("FAIL dis_ps got=%b exp=0", period_start); end
    end
    enable = 1'b1;
    step();
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL en_ps got=%b exp=1", period_start); end
    total++; if (pwm_out !== 4'b0001) begin bad++; $display("FAIL en_pwm got=%b exp=0001", pwm_out); end
    // Restart from count 0 means the next period_start is a full period away.
    n = 0;
    do begin step(); n++; end while (!period_start && n < 1000);
    total++; if (n !== 256) begin bad++; $display("FAIL en_period got=%0d exp=256", n); end
    polarity = 4'b0000;
    step();
    total++; if (pwm_out !== 4'b0000) begin bad++; $display("FAIL pol_change got=%b exp=0000", pwm_out); end
    $display("test_enable_polarity done");
  endtask

  task automatic test_edge();
    int n;
    mode = 1'b0; prescale = '0;
    set_duty(8'h80, 8'h00, 8'hFF, 8'h40);
    pulse_load();
    n = 0;
    while (!load_ack && n < 600) begin step(); n++; end
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL edge_ack got=%b exp=1", load_ack); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL edge_ps got=%b exp=1", period_start); end
    total++; if (pwm_out !== 4'b1101) begin bad++; $display("FAIL edge_first got=%b exp=1101", pwm_out); end
    measure(256);
    total++; if (m_hi[0] !== 128) begin bad++; $display("FAIL edge_hi0 got=%0d exp=128", m_hi[0]); end
    total++; if (m_first_low[0] !== 128) begin bad++; $display("FAIL edge_fall0 got=%0d exp=128", m_first_low[0]); end
    total++; if (m_hi[1] !== 0) begin bad++; $display("FAIL edge_hi1 got=%0d exp=0", m_hi[1]); end
    total++; if (m_hi[2] !== 255) begin bad++; $display("FAIL edge_hi2 got=%0d exp=255", m_hi[2]); end
    total++; if (m_first_low[2] !== 255) begin bad++; $display("FAIL edge_fall2 got=%0d exp=255", m_first_low[2]); end
    total++; if (m_hi[3] !== 64) begin bad++; $display("FAIL edge_hi3 got=%0d exp=64", m_hi[3]); end
    total++; if (m_ps !== 1) begin bad++; $display("FAIL edge_ps_cnt got=%0d exp=1", m_ps); end
    total++; if (m_ack !== 1) begin bad++; $display("FAIL edge_ack_cnt got=%0d exp=1", m_ack); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL edge_next_ps got=%b exp=1", period_start); end
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL edge_next_ack got=%b exp=0", load_ack); end
    $display("test_edge done");
  endtask

  // Starts at index 0 with ch0 = 0x80 active.
  task automatic test_midperiod_load();
    repeat (64) step();
    set_duty(8'h20, 8'h00, 8'hFF, 8'h40);
    pulse_load();
    measure(191);   // indices 65..255, still using 0x80: high for 65..127
    total++; if (m_hi[0] !== 63) begin bad++; $display("FAIL mid_old_hi got=%0d exp=63", m_hi[0]); end
    total++; if (m_ack !== 0) begin bad++; $display("FAIL mid_early_ack got=%0d exp=0", m_ack); end
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL mid_ack got=%b exp=1", load_ack); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL mid_ps got=%b exp=1", period_start); end
    total++; if (pwm_out[0] !== 1'b1) begin bad++; $display("FAIL mid_first got=%b exp=1", pwm_out[0]); end
    measure(256);
    total++; if (m_hi[0] !== 32) begin bad++; $display("FAIL mid_new_hi got=%0d exp=32", m_hi[0]); end
    total++; if (m_first_low[0] !== 32) begin bad++; $display("FAIL mid_new_fall got=%0d exp=32", m_first_low[0]); end
    total++; if (m_hi[3] !== 64) begin bad++; $display("FAIL mid_hi3 got=%0d exp=64", m_hi[3]); end
    $display("test_midperiod_load done");
  endtask

  // Starts at index 0. Index 255 is the boundary cycle.
  task automatic test_back_to_back();
    set_duty(8'h10, 8'h00, 8'hFF, 8'h40);
    pulse_load();             // now at index 1
    repeat (253) step();      // index 254
    set_duty(8'h30, 8'h00, 8'hFF, 8'h40);
    duty_load = 1'b1;
    step();                   // capture on the boundary cycle (index 255)
    duty_load = 1'b0;
    step();                   // index 0 of next period
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b exp=1", load_ack); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL b2b_ps1 got=%b exp=1", period_start); end
    measure(256);
    total++; if (m_hi[0] !== 16) begin bad++; $display("FAIL b2b_hi_10 got=%0d exp=16", m_hi[0]); end
    total++; if (m_ack !== 1) begin bad++; $display("FAIL b2b_ack_cnt1 got=%0d exp=1", m_ack); end
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b exp=1", load_ack); end
    measure(256);
    total++; if (m_hi[0] !== 48) begin bad++; $display("FAIL b2b_hi_30 got=%0d exp=48", m_hi[0]); end
    total++; if (m_ack !== 1) begin bad++; $display("FAIL b2b_ack_cnt2 got=%0d exp=1", m_ack); end
    total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack3 got=%b exp=0", load_ack); end
    $display("test_back_to_back done");
  endtask

  // Starts at index 0 with ch0 = 0x30, ch2 = 0xFF, ch3 = 0x40 active.
  task automatic test_reset_pending();
    repeat (10) step();
    set_duty(8'h05, 8'h00, 8'hFF, 8'h40);
    pulse_load();
    repeat (5) step();
    reset = 1'b1;
    step();
    total++; if (pwm_out !== 4'b0000) begin bad++; $display("FAIL rst_mid_pwm got=%b exp=0000", pwm_out); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL rst_mid_ps got=%b exp=0", period_start); end
    reset = 1'b0;
    measure(700);
    total++; if (m_ack !== 0) begin bad++; $display("FAIL rst_stale_ack got=%0d exp=0", m_ack); end
    total++; if (m_hi[0] !== 0) begin bad++; $display("FAIL rst_hi0 got=%0d exp=0", m_hi[0]); end
    total++; if (m_hi[2] !== 0) begin bad++; $display("FAIL rst_hi2 got=%0d exp=0", m_hi[2]); end
    total++; if (m_ps !== 3) begin bad++; $display("FAIL rst_ps_cnt got=%0d exp=3", m_ps); end
    $display("test_reset_pending done");
  endtask

  // Center mode, prescale 1: 510 ticks of 2 clk per period = 1020 clk.
  // Count sequence per period is 0..255 then 254..1.
  // ch0 0x40: counts 0..63 and 63..1 -> 127 ticks = 254 clk, first low at clk 128.
  // ch2 0xFF: only count 255 low -> 2 clk low at clk 510.
  // ch3 0x80: counts 0..127 and 127..1 -> 255 ticks = 510 clk.
  task automatic test_center();
    int n;
    mode = 1'b1; prescale = 4'd1;
    set_duty(8'h40, 8'h00, 8'hFF, 8'h80);
    pulse_load();
    n = 0;
    while (!load_ack && n < 1200) begin step(); n++; end
    total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL ctr_ack got=%b exp=1", load_ack); end
    total++; if (pwm_out !== 4'b1101) begin bad++; $display("FAIL ctr_first got=%b exp=1101", pwm_out); end
    measure(1020);
    total++; if (m_hi[0] !== 254) begin bad++; $display("FAIL ctr_hi0 got=%0d exp=254", m_hi[0]); end
    total++; if (m_first_low[0] !== 128) begin bad++; $display("FAIL ctr_fall0 got=%0d exp=128", m_first_low[0]); end
    total++; if (m_hi[1] !== 0) begin bad++; $display("FAIL ctr_hi1 got=%0d exp=0", m_hi[1]); end
    total++; if (m_hi[2] !== 1018) begin bad++; $display("FAIL ctr_hi2 got=%0d exp=1018", m_hi[2]); end
    total++; if (m_first_low[2] !== 510) begin bad++; $display("FAIL ctr_fall2 got=%0d exp=510", m_first_low[2]); end
    total++; if (m_hi[3] !== 510) begin bad++; $display("FAIL ctr_hi3 got=%0d exp=510", m_hi[3]); end
    total++; if (m_ps !== 1) begin bad++; $display("FAIL ctr_ps_cnt got=%0d exp=1", m_ps); end
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL ctr_next_ps got=%b exp=1", period_start); end
    $display("test_center done");
  endtask

  initial begin
    test_reset();
    test_enable_polarity();
    test_edge();
    test_midperiod_load();
    test_back_to_back();
    test_reset_pending();
    test_center();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
